mem_arbiter_2to1_delay1: RTL and testbench

- Shares one RAM_16x4096_delay1 (1-cycle read latency, no waitrequest) between two requesters: port 0 (CPU_MU0_delay1) and port 1 (test loader / DMA).
- Arbitrates each cycle, forwards the winner's command combinationally to the RAM, stalls the loser with waitrequest, and routes read data back to the issuer with a readdatavalid pulse.

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/mem_arb_rr_pick.sv | 28 ++
 rtl/mem_arbiter_2to1_delay1.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter_2to1_delay1.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared port ids, command type and helpers for the 2:1 memory arbiter
package mem_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_AUX = 1'b1;

  // Command fields are sized for RAM_16x4096_delay1.
  localparam int unsigned MEM_CMD_ADDR_W = 12;
  localparam int unsigned MEM_CMD_DATA_W = 16;

  typedef struct packed {
    logic [MEM_CMD_ADDR_W-1:0] address;
    logic                      read;
    logic                      write;
    logic [MEM_CMD_DATA_W-1:0] writedata;
  } mem_cmd_t;

  localparam mem_cmd_t MEM_CMD_IDLE = '0;

  // A read that arrives together with a write is dropped; the write wins.
  function automatic logic cmd_is_read(input mem_cmd_t cmd);
    return cmd.read & ~cmd.write;
  endfunction

  function automatic logic cmd_is_req(input mem_cmd_t cmd);
    return cmd.read | cmd.write;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    if (en && (value != 32'hFFFF_FFFF)) begin
      return value + 32'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational one-hot grant pick for two requesters
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  input  logic       fixed_priority,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        // On a conflict the port that did not win last time goes first.
        if (fixed_priority || (last_grant == PORT_AUX)) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_2to1_delay1.sv
// rtl/mem_arbiter_2to1_delay1.sv - 2:1 arbiter in front of a 1-cycle-latency RAM
// Optional saturating grant/conflict counters under MEM_ARB_STATS_EN.
module mem_arbiter_2to1_delay1
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_write,
  input  logic                  m0_read,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_write,
  input  logic                  m1_read,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write,
  output logic                  ram_read,
  output logic [DATA_WIDTH-1:0] ram_writedata,
  input  logic [DATA_WIDTH-1:0] ram_readdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grants0,
  output logic [31:0]           stat_grants1,
  output logic [31:0]           stat_conflicts
`endif
);

  mem_cmd_t   cmd0;
  mem_cmd_t   cmd1;
  mem_cmd_t   win_cmd;
  logic [1:0] req;
  logic [1:0] pick;
  logic [1:0] grant;

  port_id_t   last_grant_q;
  port_id_t   last_grant_d;
  logic       rsp_valid_q;
  logic       rsp_valid_d;
  port_id_t   rsp_id_q;
  port_id_t   rsp_id_d;

  always_comb begin
    cmd0           = MEM_CMD_IDLE;
    cmd0.address   = MEM_CMD_ADDR_W'(m0_address);
    cmd0.read      = m0_read;
    cmd0.write     = m0_write;
    cmd0.writedata = MEM_CMD_DATA_W'(m0_writedata);

    cmd1           = MEM_CMD_IDLE;
    cmd1.address   = MEM_CMD_ADDR_W'(m1_address);
    cmd1.read      = m1_read;
    cmd1.write     = m1_write;
    cmd1.writedata = MEM_CMD_DATA_W'(m1_writedata);

    req = {cmd_is_req(cmd1), cmd_is_req(cmd0)};
  end

  mem_arb_rr_pick u_pick (
    .req            (req),
    .last_grant     (last_grant_q),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant          (pick)
  );

  // Grants are masked while reset is held so nothing reaches the RAM.
  always_comb begin
    grant = pick & {2{rst}};
  end

  always_comb begin
    win_cmd = MEM_CMD_IDLE;
    if (grant[0]) begin
      win_cmd = cmd0;
    end else if (grant[1]) begin
      win_cmd = cmd1;
    end
  end

  always_comb begin
    ram_address   = ADDR_WIDTH'(win_cmd.address);
    ram_writedata = DATA_WIDTH'(win_cmd.writedata);
    ram_write     = win_cmd.write;
    ram_read      = cmd_is_read(win_cmd);

    m0_waitrequest = req[0] & ~grant[0];
    m1_waitrequest = req[1] & ~grant[1];
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant) begin
      last_grant_d = grant[1] ? PORT_AUX : PORT_CPU;
    end

    rsp_valid_d = ram_read;
    rsp_id_d    = rsp_id_q;
    if (ram_read) begin
      rsp_id_d = grant[1] ? PORT_AUX : PORT_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= PORT_AUX;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= PORT_CPU;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // The RAM read port is shared; only the matching valid qualifies the data.
  always_comb begin
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    m0_readdatavalid = rsp_valid_q & (rsp_id_q == PORT_CPU);
    m1_readdatavalid = rsp_valid_q & (rsp_id_q == PORT_AUX);
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_grants0_q;
  logic [31:0] stat_grants0_d;
  logic [31:0] stat_grants1_q;
  logic [31:0] stat_grants1_d;
  logic [31:0] stat_conflicts_q;
  logic [31:0] stat_conflicts_d;

  always_comb begin
    stat_grants0_d   = sat_inc32(stat_grants0_q, grant[0]);
    stat_grants1_d   = sat_inc32(stat_grants1_q, grant[1]);
    stat_conflicts_d = sat_inc32(stat_conflicts_q, &req);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants0_q   <= 32'd0;
      stat_grants1_q   <= 32'd0;
      stat_conflicts_q <= 32'd0;
    end else begin
      stat_grants0_q   <= stat_grants0_d;
      stat_grants1_q   <= stat_grants1_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end

  always_comb begin
    stat_grants0   = stat_grants0_q;
    stat_grants1   = stat_grants1_q;
    stat_conflicts = stat_conflicts_q;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1_delay1.sv
// tb/tb_mem_arbiter_2to1_delay1.sv - self-checking bench for mem_arbiter_2to1_delay1
// Round-robin and fixed-priority instances share stimulus; MEM_ARB_STATS_EN adds counter checks.
module tb_mem_arbiter_2to1_delay1;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] m0_address, m1_address;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [15:0] m0_writedata, m1_writedata;

  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m0_readdata, m1_readdata;
  logic [11:0] ram_address;
  logic        ram_write, ram_read;
  logic [15:0] ram_writedata;
  logic [15:0] ram_readdata;

  logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_m0_readdatavalid, fp_m1_readdatavalid;
  logic [15:0] fp_m0_readdata, fp_m1_readdata;
  logic [11:0] fp_ram_address;
  logic        fp_ram_write, fp_ram_read;
  logic [15:0] fp_ram_writedata;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_grants0, stat_grants1, stat_conflicts;
  logic [31:0] fp_stat_grants0, fp_stat_grants1, fp_stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_2to1_delay1 #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_write(ram_write), .ram_read(ram_read),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_conflicts(stat_conflicts)
`endif
  );

  mem_arbiter_2to1_delay1 #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read), .m0_writedata(m0_writedata),
    .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata), .m0_readdatavalid(fp_m0_readdatavalid),
    .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read), .m1_writedata(m1_writedata),
    .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata), .m1_readdatavalid(fp_m1_readdatavalid),
    .ram_address(fp_ram_address), .ram_write(fp_ram_write), .ram_read(fp_ram_read),
    .ram_writedata(fp_ram_writedata), .ram_readdata(16'h0000)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants0(fp_stat_grants0), .stat_grants1(fp_stat_grants1), .stat_conflicts(fp_stat_conflicts)
`endif
  );

  // RAM_16x4096_delay1 behaviour: registered read, one cycle latency.
  logic [15:0] ram_mem [0:4095];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_address] <= ram_writedata;
    if (ram_read)  ram_readdata <= ram_mem[ram_address];
  end

  typedef struct {
    logic        r0, w0;
    logic [11:0] a0;
    logic [15:0] d0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [15:0] d1;
    logic [1:0]  g;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        port;
    logic        chk;
    logic [15:0] data;
  } rsp_t;

  vec_t        vecs[$];
  rsp_t        sb[$];
  logic [15:0] model_mem [logic [11:0]];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [11:0] a0, input logic [15:0] d0,
                              input logic r1, input logic w1, input logic [11:0] a1, input logic [15:0] d1,
                              input logic [1:0] g);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g  = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_writedata = v.d0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_writedata = v.d1;
  endtask

  task automatic step(input vec_t v);
    rsp_t        e, n;
    logic        g0, g1, er, ew;
    logic [11:0] ea;
    logic [15:0] ed;
    drive(v);
    @(negedge clk);
    e = '{valid: 1'b0, port: 1'b0, chk: 1'b0, data: 16'h0};
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no queued response expected one at t=%0t", $time);
    end else begin
      e = sb.pop_front();
    end
    chk("rdv0", 32'(m0_readdatavalid), 32'(e.valid & ~e.port));
    chk("rdv1", 32'(m1_readdatavalid), 32'(e.valid & e.port));
    if (e.valid && e.chk) chk("rdata", 32'(e.port ? m1_readdata : m0_readdata), 32'(e.data));

    g0 = v.g[0];
    g1 = v.g[1];
    chk("wait0", 32'(m0_waitrequest), 32'((v.r0 | v.w0) & ~g0));
    chk("wait1", 32'(m1_waitrequest), 32'((v.r1 | v.w1) & ~g1));
    er = g0 ? (v.r0 & ~v.w0) : (g1 ? (v.r1 & ~v.w1) : 1'b0);
    ew = g0 ? v.w0 : (g1 ? v.w1 : 1'b0);
    ea = g0 ? v.a0 : (g1 ? v.a1 : 12'h000);
    ed = g0 ? v.d0 : (g1 ? v.d1 : 16'h0000);
    chk("ram_read", 32'(ram_read), 32'(er));
    chk("ram_write", 32'(ram_write), 32'(ew));
    chk("ram_address", 32'(ram_address), 32'(ea));
    if (ew) chk("ram_writedata", 32'(ram_writedata), 32'(ed));

    n.valid = er;
    n.port  = g1;
    n.chk   = er && model_mem.exists(ea);
    n.data  = n.chk ? model_mem[ea] : 16'h0000;
    if (ew) model_mem[ea] = ed;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, both;
    idle = mk(0, 0, 12'h000, 16'h0, 0, 0, 12'h000, 16'h0, 2'b00);

    vecs.push_back(mk(1, 0, 12'h010, 16'h0000, 0, 0, 12'h000, 16'h0000, 2'b01));
    vecs.push_back(mk(0, 1, 12'h010, 16'h1111, 0, 0, 12'h000, 16'h0000, 2'b01));
    vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 1, 12'h020, 16'h2222, 2'b10));
    vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 0, 1, 12'h123, 16'hBEEF, 2'b10));
    vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 1, 0, 12'h123, 16'h0000, 2'b10));
    vecs.push_back(idle);
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 0, 12'h010, 16'h0, 1, 0, 12'h020, 16'h0, (i % 2 == 0) ? 2'b01 : 2'b10));
    vecs.push_back(idle);
    vecs.push_back(mk(1, 1, 12'h030, 16'h3333, 0, 0, 12'h000, 16'h0000, 2'b01));
    vecs.push_back(mk(1, 0, 12'h030, 16'h0000, 0, 0, 12'h000, 16'h0000, 2'b01));
    vecs.push_back(mk(0, 1, 12'h040, 16'h4444, 1, 0, 12'h010, 16'h0000, 2'b10));
    vecs.push_back(mk(0, 1, 12'h040, 16'h4444, 0, 0, 12'h000, 16'h0000, 2'b01));
    vecs.push_back(mk(1, 0, 12'h040, 16'h0000, 0, 1, 12'h020, 16'h5555, 2'b10));
    vecs.push_back(mk(1, 0, 12'h040, 16'h0000, 0, 0, 12'h000, 16'h0000, 2'b01));
    vecs.push_back(mk(0, 0, 12'h000, 16'h0000, 1, 0, 12'h020, 16'h0000, 2'b10));
    vecs.push_back(idle);

    // Reset held with a pending read request.
    rst = 1'b0;
    drive(vecs[0]);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ram_read", 32'(ram_read), 32'd0);
      chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
      chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back('{valid: 1'b0, port: 1'b0, chk: 1'b0, data: 16'h0});

    foreach (vecs[i]) step(vecs[i]);

    // Reset lands between an accepted read and its response.
    step(mk(1, 0, 12'h010, 16'h0, 0, 0, 12'h000, 16'h0, 2'b01));
    rst = 1'b0;
    drive(idle);
    sb.delete();
    @(negedge clk);
    chk("midrst_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("midrst_rdv1", 32'(m1_readdatavalid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_rdv0_b", 32'(m0_readdatavalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.push_back('{valid: 1'b0, port: 1'b0, chk: 1'b0, data: 16'h0});

    for (int i = 0; i < 10; i++) begin
      both = mk(1, 0, 12'h010, 16'h0, 1, 0, 12'h020, 16'h0, (i % 2 == 0) ? 2'b01 : 2'b10);
      step(both);
    end
    step(idle);
`ifdef MEM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, 32'd10);
    chk("stat_grants0", stat_grants0, 32'd5);
    chk("stat_grants1", stat_grants1, 32'd5);
`endif

    // Fixed priority: port 1 waits as long as port 0 keeps requesting.
    drive(mk(1, 0, 12'h010, 16'h0, 1, 0, 12'h020, 16'h0, 2'b00));
    repeat (5) begin
      @(negedge clk);
      chk("fp_wait1", 32'(fp_m1_waitrequest), 32'd1);
      chk("fp_wait0", 32'(fp_m0_waitrequest), 32'd0);
      chk("fp_addr0", 32'(fp_ram_address), 32'h010);
      @(posedge clk);
      #1;
    end
    drive(mk(0, 0, 12'h000, 16'h0, 1, 0, 12'h020, 16'h0, 2'b00));
    @(negedge clk);
    chk("fp_wait1_grant", 32'(fp_m1_waitrequest), 32'd0);
    chk("fp_ram_read", 32'(fp_ram_read), 32'd1);
    chk("fp_addr1", 32'(fp_ram_address), 32'h020);
    @(posedge clk);
    #1;
    drive(idle);
    @(negedge clk);
    chk("fp_rdv1", 32'(fp_m1_readdatavalid), 32'd1);
    chk("fp_rdv0", 32'(fp_m0_readdatavalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
